// File: rtl/mul32_seq_ctrl.sv
// rtl/mul32_seq_ctrl.sv - sequencing and sign correction around the 4-stage unsigned_mul32 array multiplier
module mul32_seq_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         cnt;
    logic [1:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               neg_q;
    logic               accept;
    logic               a_neg, b_neg;
    logic [31:0]        a_mag, b_mag;
    logic [63:0]        prod;
    logic               capture;

    assign req_ready  = (state == IDLE) | ((state == DONE) & resp_ready);
    assign accept     = req_valid & req_ready & ~flush;
    assign resp_valid = (state == DONE);

    // Operands are fed as magnitudes; the sign is reapplied to the full 64-bit product
    assign a_neg = ((req_op == 2'b01) | (req_op == 2'b10)) & req_a[31];
    assign b_neg = (req_op == 2'b01) & req_b[31];
    assign a_mag = a_neg ? (32'd0 - req_a) : req_a;
    assign b_mag = b_neg ? (32'd0 - req_b) : req_b;
    assign prod  = neg_q ? (64'd0 - mul_result) : mul_result;

    assign capture = (state == RUN) & (cnt == 2'd3) & ~flush;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = RUN;
                RUN:     if (cnt == 2'd3) state_nxt = DONE;
                DONE:    if (resp_ready) state_nxt = accept ? RUN : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 2'd0;
            op_q      <= 2'd0;
            tag_q     <= '0;
            neg_q     <= 1'b0;
            mul_a     <= 32'd0;
            mul_b     <= 32'd0;
            resp_data <= 32'd0;
            resp_tag  <= '0;
        end else begin
            if (accept) begin
                op_q  <= req_op;
                tag_q <= req_tag;
                neg_q <= a_neg ^ b_neg;
                mul_a <= a_mag;
                mul_b <= b_mag;
                cnt   <= 2'd0;
            end else if (state == RUN) begin
                cnt <= cnt + 2'd1;
            end
            if (capture) begin
                resp_data <= (op_q == 2'b00) ? prod[31:0] : prod[63:32];
                resp_tag  <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// tb/tb_mul32_seq_ctrl.sv - scoreboard bench for mul32_seq_ctrl with a 3-register multiplier model
module tb_mul32_seq_ctrl;

    localparam int TAG_W = 5;
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [63:0]      mul_result;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   seen = 0;

    logic [63:0] p1 = 64'd0, p2 = 64'd0, p3 = 64'd0;

    mul32_seq_ctrl #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .flush      (flush),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: stage registers capture at E1..E3, result valid after E3
    always @(posedge clk) begin
        p1 <= {32'd0, mul_a} * {32'd0, mul_b};
        p2 <= p1;
        p3 <= p2;
    end
    assign mul_result = p3;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] a64, b64, full;
        a64  = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
        b64  = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
        full = a64 * b64;
        return (op == OP_MUL) ? full[31:0] : full[63:32];
    endfunction

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
        int   n = 0;
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check_eq("accept_timeout", req_ready, 1);
        end else begin
            e.data = ref_res(op, a, b);
            e.tag  = tag;
            e.acc  = cyc + 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_resp", resp_valid, 0);
            end else begin
                if (!seen) begin
                    check_eq("latency", cyc - sb_q[0].acc, 4);
                    seen = 1;
                end
                if (resp_ready) begin
                    check_eq("resp_data", resp_data, sb_q[0].data);
                    check_eq("resp_tag", resp_tag, sb_q[0].tag);
                    void'(sb_q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = 32'd0;
        req_b      = 32'd0;
        req_tag    = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        #1;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_data", resp_data, 0);
        check_eq("rst_resp_tag", resp_tag, 0);
        check_eq("rst_mul_a", mul_a, 0);
        check_eq("rst_mul_b", mul_b, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(OP_MUL, 32'd7, 32'd6, 5'd3);
        @(negedge clk);
        check_eq("run_req_ready", req_ready, 0);
        check_eq("run_mul_a", mul_a, 7);
        drain();

        send(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        @(negedge clk);
        check_eq("mulh_mag_a", mul_a, 1);
        check_eq("mulh_mag_b", mul_b, 1);
        drain();

        // Back-to-back with resp_ready high: DONE overlaps the next accept
        send(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5);
        send(OP_MULH,   32'h80000000, 32'h80000000, 5'd6);
        send(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
        send(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8);
        send(OP_MULHSU, 32'h80000000, 32'h00000003, 5'd9);
        drain();

        for (int i = 0; i < 8; i++) begin
            send(2'($urandom_range(0, 3)), $urandom, $urandom, 5'(i + 16));
        end
        drain();

        // Backpressure in DONE, then release together with a new request
        resp_ready = 1'b0;
        send(OP_MUL, 32'd5, 32'd9, 5'd10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        check_eq("bp_wait", resp_valid, 1);
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_data", resp_data, 45);
            check_eq("bp_tag", resp_tag, 10);
            check_eq("bp_req_ready", req_ready, 0);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        send(OP_MULHU, 32'h00000010, 32'h20000000, 5'd11);
        drain();

        // Flush at cnt==1 drops the operation
        send(OP_MUL, 32'd100, 32'd200, 5'd12);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        sb_q.delete();
        seen = 0;
        check_eq("flush_req_ready", req_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("flush_no_resp", resp_valid, 0);
        end
        @(posedge clk);
        #1;
        send(OP_MULHU, 32'd3, 32'd5, 5'd13);
        drain();

        // Asynchronous reset at cnt==2
        send(OP_MULH, 32'hFFFFFFF7, 32'd9, 5'd14);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        sb_q.delete();
        seen = 0;
        check_eq("arst_resp_valid", resp_valid, 0);
        check_eq("arst_req_ready", req_ready, 1);
        check_eq("arst_mul_a", mul_a, 0);
        check_eq("arst_mul_b", mul_b, 0);
        check_eq("arst_resp_data", resp_data, 0);
        check_eq("arst_resp_tag", resp_tag, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(OP_MUL, 32'd2, 32'd3, 5'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul32_seq_ctrl.md
# mul32_seq_ctrl

Sequencing and sign-correction front/back end for the 4-stage `unsigned_mul32` array multiplier in the execute stage. It accepts multiply requests from issue, converts signed operands to magnitudes, and drives them into the multiplier. It holds the operands stable while the multiplier's internal stages fill, then captures the 64-bit product, restores the sign, and returns the selected 32-bit half to writeback with a valid/ready handshake.

## Interface
- `TAG_W`, default 5: width of the destination-register tag carried with each request.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request this cycle.
- `req_op` input 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `req_a` input 32: rs1 value.
- `req_b` input 32: rs2 value.
- `req_tag` input TAG_W: destination tag.
- `flush` input 1: abort any in-flight operation.
- `mul_a` output 32: operand A to multiplier, registered.
- `mul_b` output 32: operand B to multiplier, registered.
- `mul_result` input 64: multiplier `result`, unsigned product.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: writeback accepts response.
- `resp_data` output 32: result half.
- `resp_tag` output TAG_W: tag of the response.

## Operation
- States: IDLE, RUN, DONE. `cnt` is a 2-bit counter, used in RUN only.
- `req_ready` = (state==IDLE) | (state==DONE & resp_ready). `flush` does not gate `req_ready`.
- Accept is `req_valid & req_ready` with `flush` low. On accept:
  - Latch op and tag.
  - `a_signed` = op∈{01,10}; `b_signed` = op==01.
  - `neg` = (a_signed & req_a[31]) ^ (b_signed & req_b[31]).
  - `mul_a` = a_signed & req_a[31] ? −req_a (mod 2^32) : req_a. `mul_b` is formed the same way from `req_b` and `b_signed`.
  - 0x80000000 magnitude is 0x80000000 interpreted unsigned, which is correct.
  - Next state RUN, cnt=0.
- RUN: cnt increments every edge. `mul_a`/`mul_b` must not change in RUN; the multiplier uses A and B combinationally in all four stages.
- At the edge where cnt==3:
  - prod = neg ? −mul_result (mod 2^64) : mul_result.
  - resp_data ← op==00 ? prod[31:0] : prod[63:32]; resp_tag ← latched tag.
  - Next state DONE.
- DONE: `resp_valid`=1. `resp_data`/`resp_tag` hold until `resp_ready`.
  - On `resp_ready` with no accept, go to IDLE.
  - On `resp_ready` with a simultaneous accept, go to RUN, cnt=0, with the new operands latched.
- `flush` high at an edge overrides everything: next state IDLE, no response, any accept that cycle is discarded. A response in DONE is also dropped.
- `mul_a`/`mul_b` keep their last value outside RUN. They change only on accept.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_tag`=0, `mul_a`=0, `mul_b`=0, cnt=0.
- Accept at edge E0 loads the operands. The multiplier stage registers capture at E1, E2, E3. `mul_result` is combinationally valid after E3 and is captured at E4.
- `resp_valid` rises in the cycle after E4. Latency is 4 clocks from accept to response.
- Throughput with `resp_ready` tied high and back-to-back requests: one result per 5 cycles. DONE overlaps with the next accept.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronous), with no response. After deassertion, the first accept is possible on the next edge.
- `resp_valid` never asserts without a preceding accept that was not flushed.

## Test plan
- MUL 7×6, tag 3, accepted at E0 → `resp_valid` in cycle after E4, `resp_data`=42, `resp_tag`=3; `req_ready` low during RUN.
- MULH 0xFFFFFFFF×0xFFFFFFFF → `mul_a`=`mul_b`=1, `resp_data`=0x00000000. MUL of the same operands → `resp_data`=0x00000001.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Backpressure: hold `resp_ready` low 3 cycles in DONE → `resp_data`/`resp_tag` stable and `req_ready` low. Then raise `resp_ready` together with a new `req_valid` → the new op is accepted at that edge and its response arrives 4 cycles later.
- `flush` at cnt==1 → no `resp_valid`, state IDLE. A request issued the cycle after completes correctly (MULHU 3×5 → 0).
- Assert `rst` asynchronously at cnt==2 → all outputs reset without waiting for a clock edge. After release, MUL 2×3 → 6 with 4-cycle latency.
